// File: rtl/eer_rl_pkg.sv
// eer_rl_pkg: packet types, phase encoding and default data width shared by the EER-RL node datapath
package eer_rl_pkg;

    localparam int unsigned DEFAULT_WORD_W = 16;

    localparam logic [2:0] PKT_HB    = 3'b000;
    localparam logic [2:0] PKT_CHA   = 3'b001;
    localparam logic [2:0] PKT_SCHED = 3'b100;
    localparam logic [2:0] PKT_DATA  = 3'b101;

    typedef enum logic [1:0] {
        PH_IDLE      = 2'd0,
        PH_SETUP     = 2'd1,
        PH_CLUSTERED = 2'd2,
        PH_COMM      = 2'd3
    } phase_t;

endpackage

// File: rtl/lowe_hyst_cmp.sv
// lowe_hyst_cmp: registered low-energy flag that sets below threshold and clears only above threshold+margin
module lowe_hyst_cmp #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [W-1:0] energy,
    input  logic [W-1:0] threshold,
    input  logic [W-1:0] margin,
    output logic         flag
);

    logic [W:0] clear_lvl;
    logic       flag_d;
    logic       flag_q;

    // set below threshold; clear only when the widened clear level did not overflow and is reached
    always_comb begin
        clear_lvl = {1'b0, threshold} + {1'b0, margin};
        flag_d    = (energy < threshold) ? 1'b1 :
                    (!clear_lvl[W] && ({1'b0, energy} >= clear_lvl)) ? 1'b0 : flag_q;
    end

    // flag register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) flag_q <= 1'b0;
        else       flag_q <= flag_d;
    end

    assign flag = flag_q;

endmodule

// File: rtl/node_info_ctrl.sv
// node_info_ctrl: per-node field latches, protocol phase FSM with heartbeat-lock timeout, and CH role control
module node_info_ctrl
    import eer_rl_pkg::*;
#(
    parameter int unsigned       WORD_W     = DEFAULT_WORD_W,
    parameter logic [WORD_W-1:0] NODE_ID    = WORD_W'(12),
    parameter int unsigned       HB_TIMEOUT = 1024,
    parameter logic [WORD_W-1:0] LOWE_HYST  = WORD_W'(16)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en_MNI,
    input  logic [2:0]        fPktType,
    input  logic [WORD_W-1:0] e_max,
    input  logic [WORD_W-1:0] e_min,
    input  logic [WORD_W-1:0] e_threshold,
    input  logic [WORD_W-1:0] energy,
    input  logic [WORD_W-1:0] ch_ID,
    input  logic [WORD_W-1:0] hops,
    input  logic [WORD_W-1:0] timeslot,
    input  logic [WORD_W-1:0] q_in,
    input  logic              q_valid,
    output logic [WORD_W-1:0] myNodeID,
    output logic [WORD_W-1:0] hopsFromSink,
    output logic [WORD_W-1:0] eMax,
    output logic [WORD_W-1:0] eMin,
    output logic [WORD_W-1:0] eThreshold,
    output logic [WORD_W-1:0] chID,
    output logic [WORD_W-1:0] mySlot,
    output logic [WORD_W-1:0] myQValue,
    output logic              role,
    output logic              low_E,
    output logic              hb_locked,
    output logic [1:0]        phase
);

    localparam int unsigned     CNT_W   = (HB_TIMEOUT > 1) ? $clog2(HB_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HB_TIMEOUT - 1);

    phase_t            phase_d, phase_q;
    logic [WORD_W-1:0] hops_d, hops_q;
    logic [WORD_W-1:0] emax_d, emax_q;
    logic [WORD_W-1:0] emin_d, emin_q;
    logic [WORD_W-1:0] thr_d, thr_q;
    logic [WORD_W-1:0] ch_d, ch_q;
    logic [WORD_W-1:0] slot_d, slot_q;
    logic [WORD_W-1:0] qval_d, qval_q;
    logic              role_d, role_q;
    logic              locked_d, locked_q;
    logic              lowe_prev_d, lowe_prev_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    logic in_sc;
    logic is_hb;
    logic is_cha;
    logic is_sched;
    logic is_data;
    logic new_round;
    logic hop_better;
    logic accepted;
    logic timeout;
    logic low_e;
    logic low_rise;

    assign in_sc      = (phase_q == PH_SETUP) || (phase_q == PH_CLUSTERED);
    assign is_hb      = en_MNI && (fPktType == PKT_HB);
    assign is_cha     = en_MNI && (fPktType == PKT_CHA);
    assign is_sched   = en_MNI && (fPktType == PKT_SCHED);
    assign is_data    = en_MNI && (fPktType == PKT_DATA);
    assign new_round  = is_hb && !in_sc;
    assign hop_better = is_hb && in_sc && (hops < hops_q);
    assign accepted   = new_round || hop_better || is_sched || (in_sc && (is_cha || is_data));
    assign timeout    = in_sc && !accepted && (cnt_q == CNT_MAX);
    assign low_rise   = low_e && !lowe_prev_q;

    lowe_hyst_cmp #(
        .W(WORD_W)
    ) u_lowe (
        .clk      (clk),
        .nrst     (nrst),
        .energy   (energy),
        .threshold(thr_q),
        .margin   (LOWE_HYST),
        .flag     (low_e)
    );

    // next-state: packet effects, then timeout release, then low-energy role drop (highest priority)
    always_comb begin
        phase_d     = phase_q;
        hops_d      = hops_q;
        emax_d      = emax_q;
        emin_d      = emin_q;
        thr_d       = thr_q;
        ch_d        = ch_q;
        slot_d      = slot_q;
        qval_d      = q_valid ? q_in : qval_q;
        role_d      = role_q;
        locked_d    = locked_q;
        lowe_prev_d = low_e;
        cnt_d       = accepted ? '0 : (in_sc && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
        if (new_round) begin
            hops_d   = hops;
            emax_d   = e_max;
            emin_d   = e_min;
            thr_d    = e_threshold;
            phase_d  = PH_SETUP;
            locked_d = 1'b1;
        end
        if (hop_better) hops_d = hops;
        if (in_sc && is_cha) begin
            ch_d    = ch_ID;
            role_d  = (ch_ID == NODE_ID);
            phase_d = PH_CLUSTERED;
        end
        if (in_sc && is_data) begin
            phase_d  = PH_COMM;
            locked_d = 1'b0;
        end
        if (is_sched) slot_d = timeslot;
        if (timeout) begin
            phase_d  = PH_IDLE;
            locked_d = 1'b0;
            role_d   = 1'b0;
        end
        if (low_rise && role_q) role_d = 1'b0;
    end

    // state and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            phase_q     <= PH_IDLE;
            hops_q      <= '0;
            emax_q      <= '0;
            emin_q      <= '0;
            thr_q       <= '0;
            ch_q        <= '0;
            slot_q      <= '0;
            qval_q      <= '0;
            role_q      <= 1'b0;
            locked_q    <= 1'b0;
            lowe_prev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            phase_q     <= phase_d;
            hops_q      <= hops_d;
            emax_q      <= emax_d;
            emin_q      <= emin_d;
            thr_q       <= thr_d;
            ch_q        <= ch_d;
            slot_q      <= slot_d;
            qval_q      <= qval_d;
            role_q      <= role_d;
            locked_q    <= locked_d;
            lowe_prev_q <= lowe_prev_d;
            cnt_q       <= cnt_d;
        end
    end

    assign myNodeID     = NODE_ID;
    assign hopsFromSink = hops_q;
    assign eMax         = emax_q;
    assign eMin         = emin_q;
    assign eThreshold   = thr_q;
    assign chID         = ch_q;
    assign mySlot       = slot_q;
    assign myQValue     = qval_q;
    assign role         = role_q;
    assign low_E        = low_e;
    assign hb_locked    = locked_q;
    assign phase        = phase_q;

endmodule

// File: tb/tb_node_info_ctrl.sv
// tb_node_info_ctrl: directed and randomized checks of node_info_ctrl against a cycle-level behavioural model
module tb_node_info_ctrl;

    localparam logic [15:0] NODE = 16'h000C;
    localparam int          TMO  = 8;
    localparam logic [15:0] HYST = 16'h0010;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en_MNI = 1'b0;
    logic [2:0]  fPktType = 3'b000;
    logic [15:0] e_max = '0, e_min = '0, e_threshold = '0, energy = 16'h0400;
    logic [15:0] ch_ID = '0, hops = '0, timeslot = '0, q_in = '0;
    logic        q_valid = 1'b0;
    logic [15:0] myNodeID, hopsFromSink, eMax, eMin, eThreshold, chID, mySlot, myQValue;
    logic        role, low_E, hb_locked;
    logic [1:0]  phase;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_phase, m_quiet;
    logic [15:0] m_hops, m_emax, m_emin, m_thr, m_ch, m_slot, m_q;
    bit          m_role, m_low, m_lowprev, m_locked;

    always #5 clk = ~clk;

    node_info_ctrl #(
        .WORD_W    (16),
        .NODE_ID   (NODE),
        .HB_TIMEOUT(TMO),
        .LOWE_HYST (HYST)
    ) dut (
        .clk(clk), .nrst(nrst), .en_MNI(en_MNI), .fPktType(fPktType),
        .e_max(e_max), .e_min(e_min), .e_threshold(e_threshold), .energy(energy),
        .ch_ID(ch_ID), .hops(hops), .timeslot(timeslot), .q_in(q_in), .q_valid(q_valid),
        .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .eMax(eMax), .eMin(eMin),
        .eThreshold(eThreshold), .chID(chID), .mySlot(mySlot), .myQValue(myQValue),
        .role(role), .low_E(low_E), .hb_locked(hb_locked), .phase(phase)
    );

    function automatic logic [116:0] dut_vec();
        return {phase, hb_locked, role, low_E, hopsFromSink, eMax, eMin, eThreshold, chID, mySlot, myQValue};
    endfunction

    function automatic logic [116:0] mdl_vec();
        logic [1:0] p;
        p = m_phase[1:0];
        return {p, m_locked, m_role, m_low, m_hops, m_emax, m_emin, m_thr, m_ch, m_slot, m_q};
    endfunction

    task automatic m_reset();
        m_phase = 0; m_quiet = 0;
        m_hops = '0; m_emax = '0; m_emin = '0; m_thr = '0; m_ch = '0; m_slot = '0; m_q = '0;
        m_role = 0; m_low = 0; m_lowprev = 0; m_locked = 0;
    endtask

    // protocol rules applied to the values present at one rising edge
    task automatic m_edge();
        bit is_sc, acc, drop, nl;
        int lim;
        lim = int'(m_thr) + int'(HYST);
        nl = (energy < m_thr) ? 1'b1 : (lim <= 65535 && int'(energy) >= lim) ? 1'b0 : m_low;
        drop = m_low && !m_lowprev && m_role;
        is_sc = (m_phase == 1 || m_phase == 2);
        acc = 0;
        if (en_MNI) begin
            case (fPktType)
                3'b000: begin
                    if (!is_sc) begin
                        m_hops = hops; m_emax = e_max; m_emin = e_min; m_thr = e_threshold;
                        m_phase = 1; m_locked = 1; acc = 1;
                    end else if (hops < m_hops) begin
                        m_hops = hops; acc = 1;
                    end
                end
                3'b001: if (is_sc) begin m_ch = ch_ID; m_role = (ch_ID == NODE); m_phase = 2; acc = 1; end
                3'b100: begin m_slot = timeslot; acc = 1; end
                3'b101: if (is_sc) begin m_phase = 3; m_locked = 0; acc = 1; end
                default: ;
            endcase
        end
        if (acc) m_quiet = 0;
        else if (is_sc) begin
            m_quiet++;
            if (m_quiet == TMO) begin m_phase = 0; m_locked = 0; m_role = 0; end
        end
        if (drop) m_role = 0;
        if (q_valid) m_q = q_in;
        m_lowprev = m_low;
        m_low = nl;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
        en_MNI = 1'b0;
        q_valid = 1'b0;
    endtask

    task automatic pkt(input logic [2:0] t);
        en_MNI = 1'b1;
        fPktType = t;
        tick();
    endtask

    task automatic test_reset();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (dut_vec() !== 117'd0) begin n_bad++; $display("FAIL reset_outputs got %h exp 0", dut_vec()); end
        n_cmp++; if (myNodeID !== 16'h000C) begin n_bad++; $display("FAIL node_id got %h exp 000c", myNodeID); end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_hb_latch();
        hops = 16'd5; e_max = 16'h0800; e_min = 16'h0010; e_threshold = 16'h0100;
        pkt(3'b000);
        n_cmp++; if ({phase, hb_locked, hopsFromSink, eThreshold} !== {2'd1, 1'b1, 16'd5, 16'h0100}) begin
            n_bad++; $display("FAIL hb_first got %h/%b/%h/%h exp 1/1/0005/0100", phase, hb_locked, hopsFromSink, eThreshold); end
        hops = 16'd3; e_threshold = 16'h0200;
        pkt(3'b000);
        n_cmp++; if ({hopsFromSink, eThreshold} !== {16'd3, 16'h0100}) begin
            n_bad++; $display("FAIL hb_minhop got %h/%h exp 0003/0100", hopsFromSink, eThreshold); end
        hops = 16'd7;
        pkt(3'b000);
        n_cmp++; if ({hopsFromSink, eThreshold} !== {16'd3, 16'h0100}) begin
            n_bad++; $display("FAIL hb_worse got %h/%h exp 0003/0100", hopsFromSink, eThreshold); end
        n_cmp++; if (dut_vec() !== mdl_vec()) begin n_bad++; $display("FAIL hb_model got %h exp %h", dut_vec(), mdl_vec()); end
    endtask

    task automatic test_cluster_lowe();
        ch_ID = 16'h000C;
        pkt(3'b001);
        n_cmp++; if ({role, phase} !== {1'b1, 2'd2}) begin n_bad++; $display("FAIL cha_self got %b/%h exp 1/2", role, phase); end
        energy = 16'h00FF;
        tick();
        n_cmp++; if ({low_E, role} !== 2'b11) begin n_bad++; $display("FAIL lowe_set got %b%b exp 11", low_E, role); end
        tick();
        n_cmp++; if ({low_E, role} !== 2'b10) begin n_bad++; $display("FAIL role_drop got %b%b exp 10", low_E, role); end
        energy = 16'h010F;
        tick();
        n_cmp++; if (low_E !== 1'b1) begin n_bad++; $display("FAIL lowe_hold got %b exp 1", low_E); end
        energy = 16'h0110;
        tick();
        n_cmp++; if (low_E !== 1'b0) begin n_bad++; $display("FAIL lowe_clear got %b exp 0", low_E); end
        n_cmp++; if (dut_vec() !== mdl_vec()) begin n_bad++; $display("FAIL lowe_model got %h exp %h", dut_vec(), mdl_vec()); end
    endtask

    task automatic test_timeout();
        pkt(3'b001);
        repeat (TMO - 1) tick();
        n_cmp++; if ({phase, role} !== {2'd2, 1'b1}) begin n_bad++; $display("FAIL tmo_early got %h/%b exp 2/1", phase, role); end
        tick();
        n_cmp++; if ({phase, hb_locked, role} !== {2'd0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL tmo_release got %h/%b/%b exp 0/0/0", phase, hb_locked, role); end
        hops = 16'd6;
        pkt(3'b000);
        repeat (6) tick();
        pkt(3'b101);
        n_cmp++; if ({phase, hb_locked} !== {2'd3, 1'b0}) begin n_bad++; $display("FAIL data_comm got %h/%b exp 3/0", phase, hb_locked); end
        pkt(3'b000);
        repeat (TMO - 1) tick();
        timeslot = 16'h0042;
        pkt(3'b100);
        n_cmp++; if ({phase, mySlot} !== {2'd1, 16'h0042}) begin n_bad++; $display("FAIL pkt_wins got %h/%h exp 1/0042", phase, mySlot); end
        repeat (TMO - 1) tick();
        n_cmp++; if (phase !== 2'd1) begin n_bad++; $display("FAIL tmo_restart got %h exp 1", phase); end
        tick();
        n_cmp++; if (phase !== 2'd0) begin n_bad++; $display("FAIL tmo_second got %h exp 0", phase); end
        n_cmp++; if (dut_vec() !== mdl_vec()) begin n_bad++; $display("FAIL tmo_model got %h exp %h", dut_vec(), mdl_vec()); end
    endtask

    task automatic test_comm_relatch();
        energy = 16'h0400;
        hops = 16'd4;
        pkt(3'b000);
        pkt(3'b101);
        hops = 16'd9; e_min = 16'h0020; e_max = 16'h0900; e_threshold = 16'h0100;
        q_in = 16'h1234; q_valid = 1'b1;
        pkt(3'b000);
        n_cmp++; if ({phase, hb_locked, hopsFromSink, eMin, eMax, myQValue} !== {2'd1, 1'b1, 16'd9, 16'h0020, 16'h0900, 16'h1234}) begin
            n_bad++; $display("FAIL comm_relatch got %h/%b/%h/%h/%h/%h exp 1/1/0009/0020/0900/1234",
                              phase, hb_locked, hopsFromSink, eMin, eMax, myQValue); end
        n_cmp++; if (dut_vec() !== mdl_vec()) begin n_bad++; $display("FAIL relatch_model got %h exp %h", dut_vec(), mdl_vec()); end
    endtask

    task automatic test_overflow_async_reset();
        pkt(3'b101);
        e_threshold = 16'hFFF8; hops = 16'd2;
        pkt(3'b000);
        energy = 16'h0000;
        tick();
        n_cmp++; if (low_E !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b exp 1", low_E); end
        energy = 16'hFFFF;
        repeat (3) tick();
        n_cmp++; if (low_E !== 1'b1) begin n_bad++; $display("FAIL ovf_noclear got %b exp 1", low_E); end
        ch_ID = 16'h0033;
        pkt(3'b001);
        n_cmp++; if (dut_vec() !== mdl_vec()) begin n_bad++; $display("FAIL ovf_model got %h exp %h", dut_vec(), mdl_vec()); end
        #3;
        nrst = 1'b0;
        #1;
        n_cmp++; if (dut_vec() !== 117'd0) begin n_bad++; $display("FAIL async_reset got %h exp 0", dut_vec()); end
        m_reset();
        en_MNI = 1'b1; fPktType = 3'b000;
        @(posedge clk);
        #1;
        en_MNI = 1'b0;
        n_cmp++; if (dut_vec() !== 117'd0) begin n_bad++; $display("FAIL reset_hold got %h exp 0", dut_vec()); end
        energy = 16'h0400;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en_MNI = ($urandom_range(0, 2) == 0);
            fPktType = 3'($urandom_range(0, 7));
            hops = 16'($urandom_range(0, 15));
            e_max = 16'($urandom);
            e_min = 16'($urandom);
            e_threshold = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFE0, 16'hFFFF)) : 16'($urandom_range(0, 16'h0300));
            energy = 16'(int'(m_thr) + int'($urandom_range(0, 48)) - 24);
            ch_ID = $urandom_range(0, 1) ? NODE : 16'($urandom_range(0, 31));
            timeslot = 16'($urandom);
            q_valid = ($urandom_range(0, 3) == 0);
            q_in = 16'($urandom);
            tick();
            n_cmp++; if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL random_cycle_%0d got %h exp %h", i, dut_vec(), mdl_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_hb_latch();
        test_cluster_lowe();
        test_timeout();
        test_comm_relatch();
        test_overflow_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/node_info_ctrl.md
# node_info_ctrl

Parametrised per-node state register and phase controller for the EER-RL sensor-node datapath, sitting between the packet filter (which supplies `fPktType` and decoded fields) and the routing/Q-learning logic. It latches hop count, energy bounds, threshold, cluster-head ID, timeslot and Q-value. It tracks the node's protocol phase with a small FSM, including a heartbeat lock that releases on timeout. It adds min-hop heartbeat acceptance and hysteretic low-energy detection.

## Interface
Parameters:
- `WORD_W`, 16, width of all data fields
- `NODE_ID`, 16'h000C, this node's ID (WORD_W bits)
- `HB_TIMEOUT`, 1024, cycles in SETUP/CLUSTERED with no data packet before the lock releases; must be ≥1
- `LOWE_HYST`, 16'h0010, energy margin above threshold needed to clear `low_E`

Ports:
- `clk`  in  1  clock, rising edge
- `nrst`  in  1  asynchronous active-low reset
- `en_MNI`  in  1  field inputs valid this cycle; qualifies every packet effect
- `fPktType`  in  3  000 HB, 001 CH announce, 100 schedule, 101 data; others ignored
- `e_max`, `e_min`, `e_threshold`, `energy`, `ch_ID`, `hops`, `timeslot`  in  WORD_W  decoded fields / live energy
- `q_in`  in  WORD_W  new Q-value from the Q compute unit
- `q_valid`  in  1  `q_in` valid
- `myNodeID`  out  WORD_W  constant `NODE_ID`
- `hopsFromSink`, `eMax`, `eMin`, `eThreshold`, `chID`, `mySlot`, `myQValue`  out  WORD_W  latched values
- `role`  out  1  1 = cluster head
- `low_E`  out  1  energy below threshold (with hysteresis)
- `hb_locked`  out  1  HB lock held
- `phase`  out  2  FSM state encoding

## Operation
- FSM states: IDLE(0), SETUP(1), CLUSTERED(2), COMM(3). Packet events require `en_MNI`=1.
- IDLE: HB → latch hops, e_max, e_min, e_threshold; go to SETUP; `hb_locked`=1.
- SETUP/CLUSTERED: HB with `hops` < `hopsFromSink` → update hops only. Energy fields are locked. Otherwise HB is ignored.
- SETUP: CH announce → `chID`←`ch_ID`; `role`←(`ch_ID`==`NODE_ID`); go to CLUSTERED.
- CLUSTERED: a further CH announce re-latches `chID`/`role`.
- Any state: schedule → `mySlot`←`timeslot`.
- SETUP/CLUSTERED: data → go to COMM; `hb_locked`=0.
- COMM: HB → behave as IDLE (new round). Full re-latch; go to SETUP.
- Timeout counter: cleared on entry to SETUP and on every accepted packet. Increments in SETUP/CLUSTERED. At count == HB_TIMEOUT-1 → go to IDLE, `hb_locked`=0, `role`=0. The counter saturates, never wraps.
- `low_E`: set when `energy` < `eThreshold`. Clear when `energy` ≥ `eThreshold`+`LOWE_HYST`. The sum is computed in WORD_W+1 bits; if it overflows, `low_E` never clears. Otherwise `low_E` holds.
- Role drop: a rising `low_E` while `role`=1 forces `role`=0 on the next cycle. A CH announce in that same cycle loses to the drop.
- `myQValue`←`q_in` when `q_valid`, independent of phase. `q_valid` with a packet in the same cycle: both take effect.

## Timing
- Reset (async assert, sync deassert by system): phase=IDLE, all WORD_W outputs 0, `role`=0, `low_E`=0, `hb_locked`=0, counter 0. `myNodeID`=NODE_ID always.
- All outputs registered. A field is visible on the cycle after the capturing edge (1-cycle latency). `low_E` lags `energy` by 1 cycle.
- No backpressure: `en_MNI` is a single-cycle strobe, and every asserted cycle is consumed.
- Reset mid-round: immediate return to reset values; any partial round is discarded.
- Timeout and accepted packet in the same cycle: the packet wins and the counter clears.

## Structure
- Shared package `eer_rl_pkg`:
  - packet-type localparams `PKT_HB`, `PKT_CHA`, `PKT_SCHED`, `PKT_DATA`
  - phase enum `phase_t`
  - default `WORD_W`
- One sub-module, `lowe_hyst_cmp`: a registered hysteresis comparator (energy, threshold, margin → flag). The rest is flat in `node_info_ctrl`.

## Test plan
- Reset, then HB hops=5, e_thr=0x0100 → next cycle phase=1, hopsFromSink=5, eThreshold=0x0100, hb_locked=1.
- Further HB hops=3, then hops=7, e_thr=0x0200 → hopsFromSink=3, eThreshold stays 0x0100.
- CH announce ch_ID=0x000C → role=1, phase=2. Then energy 0x00FF → low_E=1 and role=0 one cycle later. Energy 0x010F → low_E stays 1. Energy 0x0110 → low_E=0.
- HB_TIMEOUT=8: HB, then 8 idle cycles → phase=0, hb_locked=0, role=0. A data packet on cycle 7 instead → phase=3.
- COMM, then HB hops=9, e_min=0x0020 → full re-latch, phase=1. q_valid with q_in=0x1234 in the same cycle → myQValue=0x1234.
- e_thr=0xFFF8 with LOWE_HYST=0x10 → low_E never clears, even at energy=0xFFFF. Assert nrst mid-CLUSTERED → all outputs reset asynchronously.
